// File: rtl/seven_seg_scan_display.sv
// Multiplexed 8-digit hex display for a 32-bit processor result register.
// Once per frame one of V0/V1 is latched into a shadow register, and the
// digits are then scanned one at a time on active-low anodes and segments.
// Shadowing the value keeps every frame tear-free while V0/V1 keep changing.
module seven_seg_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] V0,
  input  logic [31:0] V1,
  input  logic        Sel,
  input  logic        Hold,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned DivW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      digit_q, digit_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            src_q, src_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            tick;
  logic            frame_end;
  logic [3:0]      nibble;
  logic [31:0]     upper;
  logic            blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state: divider, digit index, frame-boundary snapshot, and the
  // output pattern derived from the next-state values so that the outputs
  // switch on the same edge the digit advances.
  always_comb begin
    tick      = (div_cnt_q == DivLast);
    frame_end = tick && (digit_q == 3'd7);

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    digit_d   = tick ? digit_q + 3'd1 : digit_q;

    shadow_d  = shadow_q;
    src_d     = src_q;
    if (frame_end && !Hold) begin
      shadow_d = Sel ? V1 : V0;
      src_d    = Sel;
    end

    nibble = shadow_d[{digit_d, 2'b00} +: 4];
    // Digit k is a leading zero when every nibble from k upwards is zero.
    upper  = shadow_d >> {digit_d, 2'b00};
    blank  = BLANK_LZ && (digit_d != 3'd0) && (upper == 32'h0);

    an_d  = blank ? 8'hFF : ~(8'b1 << digit_d);
    seg_d = blank ? 7'h7F : hex_to_seg(nibble);
    dp_d  = !((digit_d == 3'd0) && src_d);
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt_q <= '0;
      digit_q   <= 3'd0;
      shadow_q  <= 32'h0;
      src_q     <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      src_q     <= src_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
